// File: rtl/vc_pkg.sv
// Shared types and constants for the virtual-channel arbiter: FSM encodings,
// destination selectors and the default data word width.
package vc_pkg;

  localparam int DATA_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } vc_state_t;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  // Any downstream back-pressure flag stops new pops.
  function automatic logic any_flag(input logic af0, input logic f0,
                                    input logic af1, input logic f1);
    return af0 | f0 | af1 | f1;
  endfunction

endpackage

// File: rtl/vc_grant.sv
// Weighted grant between VC0 and VC1: VC0 wins up to weight_vc0 times in a row
// while VC1 waits, then VC1 gets one grant.
module vc_grant
  import vc_pkg::*;
#(
  parameter int weight_vc0 = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic enable,
  input  logic empty_vc0,
  input  logic empty_vc1,
  output logic grant_vc0,
  output logic grant_vc1
);

  localparam int CW = $clog2(weight_vc0) + 1;
  localparam logic [CW-1:0] WMAX = CW'(weight_vc0);

  logic [CW-1:0] weight_cnt;

  // Grant selection; VC1 only wins when VC0 is empty or has used its weight.
  always_comb begin
    grant_vc0 = 1'b0;
    grant_vc1 = 1'b0;
    if (enable && !empty_vc0 && (weight_cnt < WMAX)) begin
      grant_vc0 = 1'b1;
    end else if (enable && !empty_vc1) begin
      grant_vc1 = 1'b1;
    end else begin
      grant_vc0 = 1'b0;
      grant_vc1 = 1'b0;
    end
  end

  // Consecutive-VC0 counter, only meaningful while VC1 is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_cnt <= '0;
    end else if (!init || empty_vc1 || grant_vc1) begin
      weight_cnt <= '0;
    end else if (grant_vc0 && (weight_cnt != WMAX)) begin
      weight_cnt <= weight_cnt + CW'(1);
    end else begin
      weight_cnt <= weight_cnt;
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC to two-destination arbiter: FSM, weighted pop grant and a fixed
// two-stage routing pipeline (pop at t, data at t+1, push at t+2).
module vc_arbiter
  import vc_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int dest_bit   = 4,
  parameter int weight_vc0 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic [data_width-1:0] data_in_VC0,
  input  logic [data_width-1:0] data_in_VC1,
  input  logic                  almost_full_D0,
  input  logic                  full_D0,
  input  logic                  almost_full_D1,
  input  logic                  full_D1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out_D0,
  output logic [data_width-1:0] data_out_D1,
  output logic [1:0]            state_out,
  output logic                  error_out
);

  vc_state_t             state;
  logic                  flags_hi;
  logic                  pop_en;
  logic                  grant0;
  logic                  grant1;
  logic                  stage_valid;
  logic                  stage_src;
  logic [data_width-1:0] word;
  logic                  dest;

  assign flags_hi  = any_flag(almost_full_D0, full_D0, almost_full_D1, full_D1);
  assign pop_en    = init && (state == ST_ACTIVE) && !flags_hi;
  assign pop_VC0   = grant0;
  assign pop_VC1   = grant1;
  assign state_out = state;

  vc_grant #(.weight_vc0(weight_vc0)) u_grant (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .enable    (pop_en),
    .empty_vc0 (empty_VC0),
    .empty_vc1 (empty_VC1),
    .grant_vc0 (grant0),
    .grant_vc1 (grant1)
  );

  // Source data is valid one cycle after the pop, selected by the captured tag.
  always_comb begin
    word = stage_src ? data_in_VC1 : data_in_VC0;
    dest = word[dest_bit];
  end

  // Control FSM; init low overrides every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
    end else if (!init) begin
      state <= ST_INIT;
    end else begin
      case (state)
        ST_INIT:   state <= ST_IDLE;
        ST_IDLE:   state <= (!empty_VC0 || !empty_VC1) ? ST_ACTIVE : ST_IDLE;
        ST_ACTIVE: begin
          if (flags_hi) begin
            state <= ST_PAUSE;
          end else if (empty_VC0 && empty_VC1 && !stage_valid) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_ACTIVE;
          end
        end
        ST_PAUSE:  state <= flags_hi ? ST_PAUSE : ST_ACTIVE;
        default:   state <= ST_INIT;
      endcase
    end
  end

  // Routing pipeline and sticky overflow flag; init low flushes words in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_src   <= 1'b0;
      push_D0     <= 1'b0;
      push_D1     <= 1'b0;
      data_out_D0 <= '0;
      data_out_D1 <= '0;
      error_out   <= 1'b0;
    end else if (!init) begin
      stage_valid <= 1'b0;
      stage_src   <= 1'b0;
      push_D0     <= 1'b0;
      push_D1     <= 1'b0;
      data_out_D0 <= '0;
      data_out_D1 <= '0;
      error_out   <= 1'b0;
    end else begin
      stage_valid <= grant0 | grant1;
      stage_src   <= grant1;
      push_D0     <= stage_valid && (dest == DEST_D0);
      push_D1     <= stage_valid && (dest == DEST_D1);
      data_out_D0 <= (stage_valid && (dest == DEST_D0)) ? word : '0;
      data_out_D1 <= (stage_valid && (dest == DEST_D1)) ? word : '0;
      error_out   <= error_out | (push_D0 & full_D0) | (push_D1 & full_D1);
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed testbench for vc_arbiter with small behavioural models of the VC
// FIFOs (registered read data, one cycle after pop).
module tb_vc_arbiter;
  import vc_pkg::*;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic          empty_VC0, empty_VC1;
  logic [DW-1:0] data_in_VC0, data_in_VC1;
  logic          almost_full_D0 = 1'b0, full_D0 = 1'b0;
  logic          almost_full_D1 = 1'b0, full_D1 = 1'b0;
  logic          pop_VC0, pop_VC1, push_D0, push_D1;
  logic [DW-1:0] data_out_D0, data_out_D1;
  logic [1:0]    state_out;
  logic          error_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem0 [0:31];
  logic [DW-1:0] mem1 [0:31];
  int rd0, rd1;
  int wr0 = 0;
  int wr1 = 0;

  vc_arbiter #(.data_width(DW), .dest_bit(4), .weight_vc0(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
    .data_in_VC0(data_in_VC0), .data_in_VC1(data_in_VC1),
    .almost_full_D0(almost_full_D0), .full_D0(full_D0),
    .almost_full_D1(almost_full_D1), .full_D1(full_D1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
    .push_D0(push_D0), .push_D1(push_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .state_out(state_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  assign empty_VC0 = (rd0 == wr0);
  assign empty_VC1 = (rd1 == wr1);

  // VC FIFO models: read data registered on the pop edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd0 <= 0; rd1 <= 0;
      data_in_VC0 <= '0; data_in_VC1 <= '0;
    end else begin
      if (pop_VC0) begin data_in_VC0 <= mem0[rd0[4:0]]; rd0 <= rd0 + 1; end
      if (pop_VC1) begin data_in_VC1 <= mem1[rd1[4:0]]; rd1 <= rd1 + 1; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put0(input logic [DW-1:0] d);
    mem0[wr0[4:0]] = d;
    wr0 = wr0 + 1;
  endtask

  task automatic put1(input logic [DW-1:0] d);
    mem1[wr1[4:0]] = d;
    wr1 = wr1 + 1;
  endtask

  // Empty both VC models and let the pipeline and FSM settle.
  task automatic drain();
    wr0 = rd0;
    wr1 = rd1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0;
    wr0 = 0; wr1 = 0;
    put0(6'h01); put0(6'h02); put0(6'h03);
    tick();
    n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    n_checks++; if (pop_VC0 !== 1'b0 || pop_VC1 !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b%b expected 00", pop_VC0, pop_VC1); end
    n_checks++; if (push_D0 !== 1'b0 || push_D1 !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b%b expected 00", push_D0, push_D1); end
    n_checks++; if (data_out_D0 !== 6'h00 || data_out_D1 !== 6'h00) begin n_fail++; $display("FAIL reset_data: got %h %h expected 00 00", data_out_D0, data_out_D1); end
    n_checks++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error_out); end
  endtask

  task automatic test_basic();
    logic          e_pop  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic          e_push [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] e_data [6] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h00};
    reset = 1'b0;
    tick();
    n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL basic_hold_init: got %0d expected 0", state_out); end
    init = 1'b1;
    tick();
    n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL basic_idle: got %0d expected 1", state_out); end
    n_checks++; if (pop_VC0 !== 1'b0) begin n_fail++; $display("FAIL basic_idle_pop: got %b expected 0", pop_VC0); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (pop_VC0 !== e_pop[c] || pop_VC1 !== 1'b0) begin n_fail++; $display("FAIL basic_pop c%0d: got %b%b expected %b0", c, pop_VC0, pop_VC1, e_pop[c]); end
      n_checks++; if (push_D0 !== e_push[c] || data_out_D0 !== e_data[c]) begin n_fail++; $display("FAIL basic_push c%0d: got %b/%h expected %b/%h", c, push_D0, data_out_D0, e_push[c], e_data[c]); end
      n_checks++; if (push_D1 !== 1'b0 || data_out_D1 !== 6'h00) begin n_fail++; $display("FAIL basic_no_d1 c%0d: got %b/%h expected 0/00", c, push_D1, data_out_D1); end
    end
    n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL basic_back_idle: got %0d expected 1", state_out); end
  endtask

  task automatic test_weight();
    logic e1;
    for (int i = 0; i < 10; i++) put0(DW'(i + 1));
    for (int i = 0; i < 3; i++) put1(DW'(8'h21 + i));
    for (int c = 0; c < 10; c++) begin
      tick();
      e1 = ((c % 5) == 4);
      n_checks++; if (pop_VC0 !== !e1 || pop_VC1 !== e1) begin n_fail++; $display("FAIL weight_grant c%0d: got %b%b expected %b%b", c, pop_VC0, pop_VC1, !e1, e1); end
    end
    drain();
    n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL weight_idle: got %0d expected 1", state_out); end
  endtask

  task automatic test_route();
    put1(6'h10);
    tick();
    n_checks++; if (pop_VC1 !== 1'b1 || pop_VC0 !== 1'b0) begin n_fail++; $display("FAIL route_pop: got %b%b expected 01", pop_VC0, pop_VC1); end
    tick();
    n_checks++; if (push_D1 !== 1'b0) begin n_fail++; $display("FAIL route_early: got %b expected 0", push_D1); end
    tick();
    n_checks++; if (push_D1 !== 1'b1 || data_out_D1 !== 6'h10) begin n_fail++; $display("FAIL route_d1: got %b/%h expected 1/10", push_D1, data_out_D1); end
    n_checks++; if (push_D0 !== 1'b0 || data_out_D0 !== 6'h00) begin n_fail++; $display("FAIL route_d0: got %b/%h expected 0/00", push_D0, data_out_D0); end
    drain();
  endtask

  task automatic test_pause();
    for (int i = 0; i < 8; i++) put0(DW'(8'h11 + i));
    tick();
    n_checks++; if (state_out !== 2'd2 || pop_VC0 !== 1'b1) begin n_fail++; $display("FAIL pause_start: got %0d/%b expected 2/1", state_out, pop_VC0); end
    tick();
    tick();
    almost_full_D1 = 1'b1;
    #1;
    n_checks++; if (pop_VC0 !== 1'b0) begin n_fail++; $display("FAIL pause_pop_stop: got %b expected 0", pop_VC0); end
    n_checks++; if (push_D1 !== 1'b1 || data_out_D1 !== 6'h11 || push_D0 !== 1'b0) begin n_fail++; $display("FAIL pause_inflight1: got %b/%h expected 1/11", push_D1, data_out_D1); end
    tick();
    n_checks++; if (state_out !== 2'd3) begin n_fail++; $display("FAIL pause_state: got %0d expected 3", state_out); end
    n_checks++; if (push_D1 !== 1'b1 || data_out_D1 !== 6'h12 || pop_VC0 !== 1'b0) begin n_fail++; $display("FAIL pause_inflight2: got %b/%h/%b expected 1/12/0", push_D1, data_out_D1, pop_VC0); end
    tick();
    n_checks++; if (push_D1 !== 1'b0 || pop_VC0 !== 1'b0 || state_out !== 2'd3) begin n_fail++; $display("FAIL pause_quiet: got %b/%b/%0d expected 0/0/3", push_D1, pop_VC0, state_out); end
    tick();
    almost_full_D1 = 1'b0;
    #1;
    n_checks++; if (pop_VC0 !== 1'b0 || state_out !== 2'd3) begin n_fail++; $display("FAIL pause_release: got %b/%0d expected 0/3", pop_VC0, state_out); end
    tick();
    n_checks++; if (state_out !== 2'd2 || pop_VC0 !== 1'b1) begin n_fail++; $display("FAIL pause_resume: got %0d/%b expected 2/1", state_out, pop_VC0); end
    drain();
    n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL pause_idle: got %0d expected 1", state_out); end
  endtask

  task automatic test_init_drop();
    put0(6'h05); put0(6'h06);
    tick();
    n_checks++; if (pop_VC0 !== 1'b1) begin n_fail++; $display("FAIL initdrop_pop: got %b expected 1", pop_VC0); end
    tick();
    init = 1'b0;
    #1;
    n_checks++; if (pop_VC0 !== 1'b0) begin n_fail++; $display("FAIL initdrop_pop_clear: got %b expected 0", pop_VC0); end
    tick();
    n_checks++; if (state_out !== 2'd0 || push_D0 !== 1'b0 || push_D1 !== 1'b0) begin n_fail++; $display("FAIL initdrop_flush: got %0d/%b%b expected 0/00", state_out, push_D0, push_D1); end
    n_checks++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL initdrop_error: got %b expected 0", error_out); end
    tick();
    n_checks++; if (push_D0 !== 1'b0) begin n_fail++; $display("FAIL initdrop_late_push: got %b expected 0", push_D0); end
    wr0 = rd0;
    init = 1'b1;
    tick();
    n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL initdrop_reidle: got %0d expected 1", state_out); end
  endtask

  task automatic test_error();
    put0(6'h07);
    tick();
    tick();
    n_checks++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL error_pre: got %b expected 0", error_out); end
    tick();
    n_checks++; if (push_D0 !== 1'b1 || error_out !== 1'b0) begin n_fail++; $display("FAIL error_push: got %b/%b expected 1/0", push_D0, error_out); end
    full_D0 = 1'b1;
    tick();
    n_checks++; if (error_out !== 1'b1 || state_out !== 2'd3) begin n_fail++; $display("FAIL error_set: got %b/%0d expected 1/3", error_out, state_out); end
    full_D0 = 1'b0;
    repeat (4) tick();
    n_checks++; if (error_out !== 1'b1 || state_out !== 2'd1) begin n_fail++; $display("FAIL error_sticky: got %b/%0d expected 1/1", error_out, state_out); end
    reset = 1'b1;
    #1;
    n_checks++; if (error_out !== 1'b0 || state_out !== 2'd0) begin n_fail++; $display("FAIL error_async_clear: got %b/%0d expected 0/0", error_out, state_out); end
    tick();
    reset = 1'b0;
    wr0 = 0; wr1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_weight();
    test_route();
    test_pause();
    test_init_drop();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
